// File: rtl/seq_divider_pkg.sv
// ============================================================================
// Module      : seq_divider_pkg
// Description : Shared state encoding, default width and counter sizing for
//               the sequential restoring divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_divider_pkg;

  localparam int c_DEFAULT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Step counter must hold the value W.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_divider_div_step.sv
// ============================================================================
// Module      : div_step
// Description : One combinational restoring-division step: shift in the next
//               dividend bit, trial-subtract the divisor, keep or restore.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step #(
  parameter int W = 3
) (
  input  logic [W:0]   rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] b_i,
  output logic [W:0]   rem_o,
  output logic         qbit_o
);

  logic [W:0] w_shifted;
  logic [W:0] w_trial;

  assign w_shifted = {rem_i[W-1:0], bit_i};
  assign w_trial   = w_shifted - {1'b0, b_i};
  assign qbit_o    = ~w_trial[W];
  assign rem_o     = qbit_o ? w_trial : w_shifted;

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
// Module      : seq_divider
// Description : Sequential unsigned restoring divider, one quotient bit per
//               clock, valid/ready on both operand and result sides.
//               Optional macro SEQ_DIVIDER_DBZ_EN adds the dbz port and a
//               one-cycle divide-by-zero shortcut.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int W = c_DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] q,
  output logic [W-1:0] r
`ifdef SEQ_DIVIDER_DBZ_EN
  ,
  output logic         dbz
`endif
);

  localparam int CW = cnt_width(W);

  state_e       state_q, state_d;
  logic [W-1:0] dvd_q, dvd_d;
  logic [W-1:0] div_q, div_d;
  logic [W-1:0] quo_q, quo_d;
  logic [W:0]   rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
`ifdef SEQ_DIVIDER_DBZ_EN
  logic         dbz_q, dbz_d;
`endif

  logic [W:0]   w_step_rem;
  logic         w_step_qbit;

  div_step #(.W(W)) u_step (
    .rem_i  (rem_q),
    .bit_i  (dvd_q[W-1]),
    .b_i    (div_q),
    .rem_o  (w_step_rem),
    .qbit_o (w_step_qbit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dvd_q   <= '0;
      div_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
`ifdef SEQ_DIVIDER_DBZ_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      div_q   <= div_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
`ifdef SEQ_DIVIDER_DBZ_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    div_d   = div_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
`ifdef SEQ_DIVIDER_DBZ_EN
    dbz_d   = dbz_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          dvd_d   = a;
          div_d   = b;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
`ifdef SEQ_DIVIDER_DBZ_EN
          // Zero divisor skips the steps but yields the same q/r they would.
          if (b == '0) begin
            quo_d   = '1;
            rem_d   = {1'b0, a};
            dbz_d   = 1'b1;
            state_d = ST_DONE;
          end
`endif
        end
      end
      ST_RUN: begin
        dvd_d = {dvd_q[W-2:0], 1'b0};
        rem_d = w_step_rem;
        quo_d = {quo_q[W-2:0], w_step_qbit};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
`ifdef SEQ_DIVIDER_DBZ_EN
          dbz_d   = 1'b0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The remainder always ends below the divisor, so its top bit is never
  // part of the result.
  logic unused_rem_msb;
  assign unused_rem_msb = rem_q[W];

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign q         = quo_q;
  assign r         = rem_q[W-1:0];
`ifdef SEQ_DIVIDER_DBZ_EN
  assign dbz       = dbz_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
// Module      : tb_seq_divider
// Description : Self-checking bench for seq_divider against an arithmetic
//               reference (a/b, a%b, all-ones quotient for b=0).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_divider;

  localparam int W = 3;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] q;
  logic [W-1:0] r;
`ifdef SEQ_DIVIDER_DBZ_EN
  logic         dbz;
`endif

  int n_total = 0;
  int n_bad   = 0;

  seq_divider #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .r         (r)
`ifdef SEQ_DIVIDER_DBZ_EN
    ,
    .dbz       (dbz)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Issue one division, verify latency/result, optionally stall the consumer.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input int hold);
    int guard;
    int lat;
    int exp_lat;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    eq = (tb == '0) ? '1 : W'(ta / tb);
    er = (tb == '0) ? ta : W'(ta % tb);
`ifdef SEQ_DIVIDER_DBZ_EN
    exp_lat = (tb == '0) ? 1 : W + 1;
`else
    exp_lat = W + 1;
`endif
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("ready_wait", 32'(guard < 50), 32'(1));
    a = ta;
    b = tb;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      check("busy_ready", 32'(in_ready), 32'(0));
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("q", 32'(q), 32'(eq));
    check("r", 32'(r), 32'(er));
    check("done_ready", 32'(in_ready), 32'(0));
    if (tb != '0) begin
      check("identity", 32'(q) * 32'(tb) + 32'(r), 32'(ta));
    end
`ifdef SEQ_DIVIDER_DBZ_EN
    check("dbz", 32'(dbz), 32'(tb == '0));
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = W'($urandom_range(0, (1 << W) - 1));
      b = W'($urandom_range(0, (1 << W) - 1));
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 32'(1));
      check("hold_q", 32'(q), 32'(eq));
      check("hold_r", 32'(r), 32'(er));
      check("hold_ready", 32'(in_ready), 32'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_valid", 32'(out_valid), 32'(0));
    check("post_ready", 32'(in_ready), 32'(1));
`ifdef SEQ_DIVIDER_DBZ_EN
    check("post_dbz", 32'(dbz), 32'(0));
`endif
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_ready", 32'(in_ready), 32'(1));
    check("rst_valid", 32'(out_valid), 32'(0));
    check("rst_q", 32'(q), 32'(0));
    check("rst_r", 32'(r), 32'(0));
`ifdef SEQ_DIVIDER_DBZ_EN
    check("rst_dbz", 32'(dbz), 32'(0));
`endif

    run_op(3'd7, 3'd2, 0);
    run_op(3'd6, 3'd3, 0);
    run_op(3'd2, 3'd5, 0);
    run_op(3'd5, 3'd0, 0);
    run_op(3'd7, 3'd1, 5);

    // Abort in the second RUN cycle.
    a = 3'd7;
    b = 3'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_q", 32'(q), 32'(0));
    check("abort_r", 32'(r), 32'(0));
    check("abort_valid", 32'(out_valid), 32'(0));
    check("abort_ready", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(3'd4, 3'd2, 0);

    for (int ai = 0; ai < (1 << W); ai++) begin
      for (int bi = 0; bi < (1 << W); bi++) begin
        run_op(W'(ai), W'(bi), 0);
      end
    end

    for (int k = 0; k < 40; k++) begin
      run_op(W'($urandom_range(0, (1 << W) - 1)),
             W'($urandom_range(0, (1 << W) - 1)),
             int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
